// File: rtl/alu_pkg.sv
// Shared opcode constants, command record and opcode helpers for the ALU issue path.
// No logic of its own; pure types and functions.
// Tags wider than CMD_TAG_W are not representable in cmd_t.
package alu_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  // Tag field width carried in the command record; instances keep TAG_W <= this.
  localparam int CMD_TAG_W = 4;

  typedef struct packed {
    logic [31:0]          a;
    logic [31:0]          b;
    logic [2:0]           op;
    logic [CMD_TAG_W-1:0] tag;
  } cmd_t;

  function automatic logic is_legal_op(input logic [2:0] op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) ||
           (op == OP_SUB) || (op == OP_SLT);
  endfunction

  // ADD/SUB are the only opcodes whose carry and overflow flags are meaningful.
  function automatic logic is_addsub_op(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous circular-buffer FIFO with occupancy count, full and empty flags.
// Latency: a word pushed at edge N is visible on rdata_o after edge N.
// Backpressure: pushes while full and pops while empty are ignored; no bypass.
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  // Full is judged on the current count, so a pop cannot make room for a same-cycle push.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointer and occupancy next state; pointers wrap naturally at DEPTH (power of 2).
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) wptr_d = wptr_q + PTR_W'(1);
    if (do_pop)  rptr_d = rptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage array; contents are don't-care until written, so it carries no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/alu_cmd_issue.sv
// Issue stage for the 32-bit combinational ALU: command FIFO -> issue register -> result register.
// Latency: command accepted at edge N drives the ALU after N+1, result valid after N+2; 1 cmd/cycle.
// Backpressure: res_ready=0 holds result and issue stages, FIFO fills; capacity is DEPTH+2 commands.
module alu_cmd_issue
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [31:0]            cmd_a,
  input  logic [31:0]            cmd_b,
  input  logic [2:0]             cmd_op,
  input  logic [TAG_W-1:0]       cmd_tag,
  output logic [31:0]            alu_a,
  output logic [31:0]            alu_b,
  output logic [2:0]             alu_op,
  input  logic [31:0]            alu_r,
  input  logic                   alu_cout,
  input  logic                   alu_vout,
  input  logic                   alu_z,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [31:0]            res_r,
  output logic                   res_cout,
  output logic                   res_vout,
  output logic                   res_z,
  output logic                   res_err,
  output logic [TAG_W-1:0]       res_tag,
  output logic                   sticky_ovf,
  input  logic                   clr_sticky,
  output logic [$clog2(DEPTH):0] fifo_count
);

  cmd_t fifo_wdata, fifo_rdata;
  logic fifo_full, fifo_empty, fifo_pop;

  assign fifo_wdata = '{a: cmd_a, b: cmd_b, op: cmd_op, tag: CMD_TAG_W'(cmd_tag)};
  assign cmd_ready  = !fifo_full;

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(cmd_t))
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (cmd_valid),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  cmd_t             issue_q, issue_d;
  logic             issue_vld_q, issue_vld_d;
  logic             res_vld_q, res_vld_d;
  logic [31:0]      res_r_q, res_r_d;
  logic             res_cout_q, res_cout_d;
  logic             res_vout_q, res_vout_d;
  logic             res_z_q, res_z_d;
  logic             res_err_q, res_err_d;
  logic [TAG_W-1:0] res_tag_q, res_tag_d;
  logic             sticky_q, sticky_d;

  logic res_adv, issue_load, capture, cap_legal, cap_addsub;

  // Result register takes a new value when it is empty or being consumed this cycle.
  assign res_adv    = !res_vld_q || res_ready;
  // Issue register refills when empty or when its current command moves into the result stage.
  assign issue_load = !issue_vld_q || res_adv;
  assign fifo_pop   = issue_load && !fifo_empty;
  assign capture    = res_adv && issue_vld_q;
  assign cap_legal  = is_legal_op(issue_q.op);
  assign cap_addsub = is_addsub_op(issue_q.op);

  assign alu_a  = issue_q.a;
  assign alu_b  = issue_q.b;
  assign alu_op = issue_q.op;

  // Issue stage next state; operands hold their last value when no new command arrives.
  always_comb begin
    issue_vld_d = issue_vld_q;
    issue_d     = issue_q;
    if (issue_load) begin
      issue_vld_d = !fifo_empty;
      if (!fifo_empty) issue_d = fifo_rdata;
    end
  end

  // Result capture: flags filtered by opcode class, illegal opcodes zero the payload but keep the tag.
  always_comb begin
    res_vld_d  = res_vld_q;
    res_r_d    = res_r_q;
    res_cout_d = res_cout_q;
    res_vout_d = res_vout_q;
    res_z_d    = res_z_q;
    res_err_d  = res_err_q;
    res_tag_d  = res_tag_q;
    if (res_adv) res_vld_d = issue_vld_q;
    if (capture) begin
      res_r_d    = cap_legal ? alu_r : 32'd0;
      res_cout_d = cap_addsub && alu_cout;
      res_vout_d = cap_addsub && alu_vout;
      res_z_d    = cap_legal && alu_z;
      res_err_d  = !cap_legal;
      res_tag_d  = TAG_W'(issue_q.tag);
    end
  end

  // Sticky overflow: a captured ADD/SUB overflow takes priority over a same-cycle clear.
  always_comb begin
    sticky_d = sticky_q;
    if (capture && cap_addsub && alu_vout) sticky_d = 1'b1;
    else if (clr_sticky)                   sticky_d = 1'b0;
  end

  // Pipeline state registers; reset discards everything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_q     <= '0;
      issue_vld_q <= 1'b0;
      res_vld_q   <= 1'b0;
      res_r_q     <= '0;
      res_cout_q  <= 1'b0;
      res_vout_q  <= 1'b0;
      res_z_q     <= 1'b0;
      res_err_q   <= 1'b0;
      res_tag_q   <= '0;
      sticky_q    <= 1'b0;
    end else begin
      issue_q     <= issue_d;
      issue_vld_q <= issue_vld_d;
      res_vld_q   <= res_vld_d;
      res_r_q     <= res_r_d;
      res_cout_q  <= res_cout_d;
      res_vout_q  <= res_vout_d;
      res_z_q     <= res_z_d;
      res_err_q   <= res_err_d;
      res_tag_q   <= res_tag_d;
      sticky_q    <= sticky_d;
    end
  end

  assign res_valid  = res_vld_q;
  assign res_r      = res_r_q;
  assign res_cout   = res_cout_q;
  assign res_vout   = res_vout_q;
  assign res_z      = res_z_q;
  assign res_err    = res_err_q;
  assign res_tag    = res_tag_q;
  assign sticky_ovf = sticky_q;

endmodule

// File: tb/tb_alu_cmd_issue.sv
// Directed bench for alu_cmd_issue with a behavioural ALU attached to the alu_* ports.
// Inputs change at negedge+2, handshakes are logged at negedge+3, edges are at posedge.
// Ends with a single summary line.
module tb_alu_cmd_issue;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_a = '0, cmd_b = '0;
  logic [2:0]  cmd_op = '0;
  logic [3:0]  cmd_tag = '0;
  logic [31:0] alu_a, alu_b, alu_r;
  logic [2:0]  alu_op;
  logic        alu_cout, alu_vout, alu_z;
  logic        res_valid, res_ready = 1'b0;
  logic [31:0] res_r;
  logic        res_cout, res_vout, res_z, res_err;
  logic [3:0]  res_tag;
  logic        sticky_ovf, clr_sticky = 1'b0;
  logic [2:0]  fifo_count;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] r;
    logic        c, v, z, e;
    logic [3:0]  tag;
    int          cyc;
  } rec_t;
  rec_t rq[$];

  alu_cmd_issue #(.DEPTH(4), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_tag(cmd_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_r(alu_r), .alu_cout(alu_cout), .alu_vout(alu_vout), .alu_z(alu_z),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_r(res_r), .res_cout(res_cout), .res_vout(res_vout), .res_z(res_z),
    .res_err(res_err), .res_tag(res_tag),
    .sticky_ovf(sticky_ovf), .clr_sticky(clr_sticky), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ALU; illegal codes produce garbage with every flag raised.
  logic [32:0] alu_sum;
  always_comb begin
    alu_sum  = '0;
    alu_r    = '0;
    alu_cout = 1'b0;
    alu_vout = 1'b0;
    alu_z    = 1'b0;
    case (alu_op)
      OP_AND: alu_r = alu_a & alu_b;
      OP_OR:  alu_r = alu_a | alu_b;
      OP_ADD: begin
        alu_sum  = {1'b0, alu_a} + {1'b0, alu_b};
        alu_r    = alu_sum[31:0];
        alu_cout = alu_sum[32];
        alu_vout = (alu_a[31] == alu_b[31]) && (alu_r[31] != alu_a[31]);
      end
      OP_SUB: begin
        alu_sum  = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
        alu_r    = alu_sum[31:0];
        alu_cout = alu_sum[32];
        alu_vout = (alu_a[31] != alu_b[31]) && (alu_r[31] != alu_a[31]);
      end
      OP_SLT: alu_r = {31'd0, $signed(alu_a) < $signed(alu_b)};
      default: begin
        alu_r    = alu_a ^ alu_b;
        alu_cout = 1'b1;
        alu_vout = 1'b1;
      end
    endcase
    if (is_legal_op(alu_op)) alu_z = (alu_r == 32'd0);
    else                     alu_z = 1'b1;
  end

  // Log every result handshake that will complete at the coming posedge.
  always @(negedge clk) begin
    #3;
    if (rst_n && res_valid && res_ready)
      rq.push_back('{res_r, res_cout, res_vout, res_z, res_err, res_tag, cyc});
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] op, input logic [3:0] tag);
    cmd_valid = 1'b1;
    cmd_a     = a;
    cmd_b     = b;
    cmd_op    = op;
    cmd_tag   = tag;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_res(input int n);
    int i = 0;
    while (rq.size() < n && i < 50) begin
      tick();
      i++;
    end
    chk("res_count", rq.size(), n);
  endtask

  task automatic wait_valid();
    int i = 0;
    while (!res_valid && i < 20) begin
      tick();
      i++;
    end
    chk("res_valid_seen", res_valid, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k, acc;
    logic rdy;

    // Reset state.
    repeat (2) tick();
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_r", res_r, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_sticky", sticky_ovf, 0);
    chk("rst_count", fifo_count, 0);
    rst_n = 1'b1;
    res_ready = 1'b1;
    tick();
    chk("idle_cmd_ready", cmd_ready, 1);

    // ADD with signed overflow, and accept-to-valid latency.
    rq.delete();
    cmd_valid = 1'b1; cmd_a = 32'h6F0F0F5A; cmd_b = 32'h6F0F0F5A; cmd_op = OP_ADD; cmd_tag = 4'd1;
    k = 0;
    do begin
      tick();
      cmd_valid = 1'b0;
      k++;
    end while (!res_valid && k < 10);
    chk("add_latency", k, 3);
    wait_res(1);
    if (rq.size() >= 1) begin
      chk("add_r", rq[0].r, 32'hDE1E1EB4);
      chk("add_vout", rq[0].v, 1);
      chk("add_cout", rq[0].c, 0);
      chk("add_z", rq[0].z, 0);
      chk("add_err", rq[0].e, 0);
      chk("add_tag", rq[0].tag, 1);
    end
    chk("add_sticky", sticky_ovf, 1);

    // SUB of equal operands, then a clear pulse.
    rq.delete();
    send(32'h6F0F0F5A, 32'h6F0F0F5A, OP_SUB, 4'd2);
    wait_res(1);
    if (rq.size() >= 1) begin
      chk("sub_r", rq[0].r, 0);
      chk("sub_z", rq[0].z, 1);
      chk("sub_vout", rq[0].v, 0);
      chk("sub_cout", rq[0].c, 1);
    end
    chk("sub_sticky_kept", sticky_ovf, 1);
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    chk("clr_sticky", sticky_ovf, 0);

    // Back-to-back logical ops on consecutive cycles.
    rq.delete();
    send(32'hEF0B4D5A, 32'h6F4F0B5A, OP_AND, 4'd3);
    send(32'hEF0B4D5A, 32'h6F4F0B5A, OP_OR,  4'd4);
    send(32'hEF0B4D5A, 32'h6F4F0B5A, OP_SLT, 4'd5);
    wait_res(3);
    if (rq.size() >= 3) begin
      chk("and_r", rq[0].r, 32'h6F0B095A);
      chk("or_r",  rq[1].r, 32'hEF4F4F5A);
      chk("slt_r", rq[2].r, 32'h00000001);
      chk("logic_flags", {rq[0].c, rq[0].v, rq[1].c, rq[1].v, rq[2].c, rq[2].v}, 0);
      chk("b2b_gap1", rq[1].cyc - rq[0].cyc, 1);
      chk("b2b_gap2", rq[2].cyc - rq[1].cyc, 1);
    end

    // Illegal opcode: payload and flags masked, tag kept, sticky untouched.
    rq.delete();
    send(32'd3, 32'd4, 3'b100, 4'd5);
    wait_res(1);
    if (rq.size() >= 1) begin
      chk("ill_err", rq[0].e, 1);
      chk("ill_r", rq[0].r, 0);
      chk("ill_flags", {rq[0].c, rq[0].v, rq[0].z}, 0);
      chk("ill_tag", rq[0].tag, 5);
    end
    chk("ill_sticky", sticky_ovf, 0);

    // Overflow capture coinciding with a held clear: set wins.
    clr_sticky = 1'b1;
    send(32'h6F0F0F5A, 32'h6F0F0F5A, OP_ADD, 4'd6);
    wait_valid();
    clr_sticky = 1'b0;
    chk("set_wins", sticky_ovf, 1);
    repeat (3) tick();

    // Backpressure: 8 offers, capacity DEPTH+2.
    rq.delete();
    res_ready = 1'b0;
    acc = 0;
    cmd_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cmd_a = 32'(acc); cmd_b = 32'd1; cmd_op = OP_ADD; cmd_tag = 4'(acc);
      rdy = cmd_ready;
      tick();
      if (rdy) acc++;
    end
    cmd_valid = 1'b0;
    chk("bp_accepted", acc, 6);
    chk("bp_cmd_ready", cmd_ready, 0);
    chk("bp_count", fifo_count, 4);
    repeat (2) tick();
    chk("bp_hold_valid", res_valid, 1);
    chk("bp_hold_r", res_r, 1);
    chk("bp_hold_tag", res_tag, 0);
    res_ready = 1'b1;
    wait_res(6);
    for (int i = 0; i < 6 && i < rq.size(); i++) begin
      chk("bp_tag", rq[i].tag, 4'(i));
      chk("bp_r", rq[i].r, 32'(i + 1));
      if (i > 0) chk("bp_gap", rq[i].cyc - rq[i-1].cyc, 1);
    end
    repeat (3) tick();
    chk("bp_no_dup", rq.size(), 6);

    // Asynchronous reset with three commands in flight.
    rq.delete();
    res_ready = 1'b0;
    send(32'h6F0F0F5A, 32'h6F0F0F5A, OP_ADD, 4'd7);
    send(32'h6F0F0F5A, 32'h6F0F0F5A, OP_ADD, 4'd8);
    send(32'h6F0F0F5A, 32'h6F0F0F5A, OP_ADD, 4'd9);
    chk("pre_rst_valid", res_valid, 1);
    chk("pre_rst_sticky", sticky_ovf, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", res_valid, 0);
    chk("arst_payload", {res_r, res_cout, res_vout, res_z, res_err, res_tag}, 0);
    chk("arst_alu", {alu_a, alu_b, alu_op}, 0);
    chk("arst_sticky", sticky_ovf, 0);
    chk("arst_count", fifo_count, 0);
    tick();
    rst_n = 1'b1;
    res_ready = 1'b1;
    repeat (5) tick();
    chk("post_rst_no_result", rq.size(), 0);
    chk("post_rst_valid", res_valid, 0);
    chk("post_rst_cmd_ready", cmd_ready, 1);
    chk("post_rst_count", fifo_count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
